// File: rtl/input_buffer_logic.sv
// input_buffer_logic: assembles four strobed bytes into a 32-bit packet held until routed
module input_buffer_logic #(
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            data_transfer_in,
  input  logic [7:0]      input_data,
  input  logic            data_routed,
  output logic            ready_to_receive,
  output logic            input_buffer_loaded,
  output logic [3:0][7:0] data_out,
  output logic            err_overflow,
  output logic            err_timeout
);
  localparam int TW = IDLE_TIMEOUT > 0 ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT > 0 ? IDLE_TIMEOUT - 1 : 0);
  typedef enum logic {RECEIVE, FULL} state_t;
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [3:0][7:0] asm_reg;
  logic [TW-1:0] idle;
  logic accept, complete, expire;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= RECEIVE;
    else state <= state_nx;
  always_comb
    state_nx = (state == RECEIVE && complete) ? FULL :
               (state == FULL && data_routed) ? RECEIVE : state;
  always_comb begin
    accept = state == RECEIVE && data_transfer_in;
    complete = accept && cnt == 2'd3;
    expire = IDLE_TIMEOUT != 0 && state == RECEIVE && !data_transfer_in && cnt != 2'd0 && idle == IDLE_LAST;
  end
  // a strobe on the expiry edge is accepted, so accept is checked before expire
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      asm_reg <= '0;
      data_out <= '0;
      idle <= '0;
      ready_to_receive <= 1'b1;
      input_buffer_loaded <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ready_to_receive <= state_nx == RECEIVE;
      input_buffer_loaded <= complete;
      err_overflow <= state == FULL && data_transfer_in;
      err_timeout <= expire;
      if (accept) begin
        asm_reg[2'd3 - cnt] <= input_data;
        cnt <= cnt + 2'd1;
        idle <= '0;
      end else if (expire || cnt == 2'd0) begin
        cnt <= '0;
        idle <= '0;
      end else if (state == RECEIVE) idle <= idle + 1'b1;
      if (complete) data_out <= {asm_reg[3:1], input_data};
    end
endmodule

// File: tb/tb_input_buffer_logic.sv
// tb_input_buffer_logic: directed stimulus checked against a queue-based packet model
module tb_input_buffer_logic;
  localparam int TO = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic data_transfer_in = 1'b0;
  logic [7:0] input_data = '0;
  logic data_routed = 1'b0;
  logic ready_to_receive, input_buffer_loaded, err_overflow, err_timeout;
  logic [3:0][7:0] data_out;
  int errors = 0;
  int checks = 0;
  logic started = 1'b0;

  input_buffer_logic #(.IDLE_TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .data_transfer_in(data_transfer_in),
    .input_data(input_data), .data_routed(data_routed),
    .ready_to_receive(ready_to_receive), .input_buffer_loaded(input_buffer_loaded),
    .data_out(data_out), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  logic m_full, m_ld, m_ovf, m_to;
  logic [7:0] m_q[$];
  int m_idle;
  logic [31:0] m_out;

  task automatic model_reset();
    m_full = 1'b0; m_ld = 1'b0; m_ovf = 1'b0; m_to = 1'b0;
    m_q.delete(); m_idle = 0; m_out = '0;
  endtask

  task automatic model_step(input logic s, input logic [7:0] d, input logic r);
    m_ld = 1'b0; m_ovf = 1'b0; m_to = 1'b0;
    if (m_full) begin
      if (s) m_ovf = 1'b1;
      if (r) m_full = 1'b0;
    end else if (s) begin
      m_q.push_back(d);
      m_idle = 0;
      if (m_q.size() == 4) begin
        m_out = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_q.delete();
        m_full = 1'b1;
        m_ld = 1'b1;
      end
    end else if (m_q.size() != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_q.delete();
        m_idle = 0;
        m_to = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock)
    if (started) begin
      check("cyc_ready", ready_to_receive, !m_full);
      check("cyc_loaded", input_buffer_loaded, m_ld);
      check("cyc_data_out", data_out, m_out);
      check("cyc_overflow", err_overflow, m_ovf);
      check("cyc_timeout", err_timeout, m_to);
    end

  task automatic tick(input logic s, input logic [7:0] d, input logic r);
    data_transfer_in = s; input_data = d; data_routed = r;
    @(posedge clock);
    #1;
    model_step(s, d, r);
    data_transfer_in = 1'b0; data_routed = 1'b0;
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) tick(1'b1, w[i*8 +: 8], 1'b0);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready", ready_to_receive, 1);
    check("rst_loaded", input_buffer_loaded, 0);
    check("rst_data_out", data_out, 0);
    check("rst_overflow", err_overflow, 0);
    check("rst_timeout", err_timeout, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int ovf_n;
    model_reset();
    started = 1'b1;
    repeat (2) @(posedge clock);
    check("init_ready", ready_to_receive, 1);
    check("init_data_out", data_out, 0);
    #2 reset_n = 1'b1;
    send4(32'hA1B2C3D4);
    check("p1_loaded", input_buffer_loaded, 1);
    check("p1_data", data_out, 32'hA1B2C3D4);
    check("p1_ready_low", ready_to_receive, 0);
    tick(1'b0, 8'h00, 1'b0);
    check("p1_pulse_end", input_buffer_loaded, 0);
    check("p1_still_full", ready_to_receive, 0);
    ovf_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(i % 3 == 1, 8'(240 + i), 1'b0);
      ovf_n += int'(err_overflow);
      check("hold_data", data_out, 32'hA1B2C3D4);
    end
    check("ovf_count", ovf_n, 3);
    tick(1'b0, 8'h00, 1'b1);
    check("release_ready", ready_to_receive, 1);
    send4(32'h11223344);
    check("p2_data", data_out, 32'h11223344);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h55, 1'b0);
    tick(1'b1, 8'h66, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      check("timeout_pulse", err_timeout, i == 3);
    end
    tick(1'b1, 8'h77, 1'b0);
    check("timeout_clear", err_timeout, 0);
    tick(1'b1, 8'h88, 1'b0);
    tick(1'b1, 8'h99, 1'b0);
    check("old_data_kept", data_out, 32'h11223344);
    tick(1'b1, 8'hAA, 1'b0);
    check("p3_data", data_out, 32'h778899AA);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      check("no_early_timeout", err_timeout, 0);
    end
    tick(1'b1, 8'h04, 1'b0);
    check("expiry_edge_timeout", err_timeout, 0);
    check("expiry_edge_loaded", input_buffer_loaded, 1);
    check("p4_data", data_out, 32'h01020304);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h05, 1'b0);
    tick(1'b1, 8'h06, 1'b0);
    tick(1'b1, 8'h07, 1'b0);
    tick(1'b1, 8'h08, 1'b1);
    check("routed_on_load_ready", ready_to_receive, 0);
    check("p5_data", data_out, 32'h05060708);
    tick(1'b0, 8'h00, 1'b0);
    check("routed_ignored", ready_to_receive, 0);
    tick(1'b1, 8'hEE, 1'b1);
    check("release_edge_ovf", err_overflow, 1);
    check("release_edge_ready", ready_to_receive, 1);
    tick(1'b1, 8'hC1, 1'b0);
    tick(1'b1, 8'hC2, 1'b0);
    async_reset();
    send4(32'hD1D2D3D4);
    check("post_rst_data", data_out, 32'hD1D2D3D4);
    async_reset();
    send4(32'hE1E2E3E4);
    check("post_full_rst_data", data_out, 32'hE1E2E3E4);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/input_buffer_logic.md
# input_buffer_logic

Receive-side packet assembler for the router datapath. Collects a byte stream from an upstream serializer using a strobe plus ready handshake, and assembles four bytes into one 32-bit packet, first byte in the most significant lane. It presents the packet to the routing stage with a one-cycle `input_buffer_loaded` pulse and holds it until the routing stage acknowledges with `data_routed`. Partial packets that stall beyond a timeout are discarded and flagged.

## Interface
- `IDLE_TIMEOUT`, default 16: cycles without a strobe, while a partial packet is held, before the partial packet is discarded. 0 disables the timeout. Counter width is $clog2(IDLE_TIMEOUT+1).
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `data_transfer_in`  in  1  byte strobe from upstream; `input_data` is valid when high.
- `input_data`  in  8  incoming byte.
- `data_routed`  in  1  routing stage has consumed `data_out`; releases the packet.
- `ready_to_receive`  out  1  registered; block accepts bytes while high.
- `input_buffer_loaded`  out  1  registered one-cycle pulse: `data_out` holds a new packet.
- `data_out`  out  [3:0][7:0]  assembled packet; `data_out[3]` holds the first byte received.
- `err_overflow`  out  1  one-cycle pulse: a strobe arrived while not accepting.
- `err_timeout`  out  1  one-cycle pulse: a partial packet was discarded.

## Operation
- States:
  - RECEIVE: accepting bytes.
  - FULL: packet held, no bytes accepted.
- Internal assembly register `asm[3:0][7:0]` and byte counter `cnt[1:0]`. `data_out` is a separate register and changes only when a packet completes.
- RECEIVE, strobe high:
  - Write `asm[3-cnt] <= input_data`, then `cnt <= cnt+1`.
  - If `cnt==3` at that edge: `data_out <= {asm[3:1], input_data}`, `cnt <= 0`, `input_buffer_loaded <= 1`, `ready_to_receive <= 0`, go to FULL.
- FULL:
  - `data_out` is stable.
  - When `data_routed` is high: go to RECEIVE, `ready_to_receive <= 1`.
  - `data_routed` is ignored in RECEIVE, including on the edge that completes a packet.
- Overflow:
  - A strobe while in FULL drops the byte and pulses `err_overflow`.
  - A strobe on the same edge that `data_routed` releases FULL is also dropped and flagged. The release takes effect at that edge; acceptance starts the next edge.
- Timeout:
  - Idle counter clears on every accepted strobe and whenever `cnt==0`.
  - It increments each RECEIVE cycle with `cnt!=0` and no strobe.
  - When it reaches `IDLE_TIMEOUT`: `cnt <= 0`, counter clears, `err_timeout` pulses, and `data_out` is untouched.
  - A strobe on the same edge as expiry is accepted and takes priority, so no timeout occurs.
- Reset (asynchronous, any time, including mid-packet or in FULL):
  - State RECEIVE, `cnt=0`, `asm=0`, `data_out=0`, idle counter 0.
  - `ready_to_receive=1`, `input_buffer_loaded=0`, `err_overflow=0`, `err_timeout=0`.
  - Any partial packet is lost silently, with no error pulse.

## Timing
- Accepted strobes may be back to back, one byte per cycle, or have gaps of any length below `IDLE_TIMEOUT`.
- Fourth byte accepted at edge N:
  - `input_buffer_loaded` is high for the cycle following N only.
  - `data_out` is valid from N onward.
  - `ready_to_receive` is low from N.
- `data_routed` sampled high at edge M > N: `ready_to_receive` is high after M, and the earliest next byte is accepted at M+1.
- Minimum packet period is 5 cycles: 4 bytes plus 1 release cycle, with `data_routed` asserted in the cycle after the load pulse.
- Error pulses last exactly one cycle per offending edge.
- `ready_to_receive` is advisory. Upstream registers its strobe, so it must sample `ready_to_receive` before launching a byte. A sender that launches on stale ready gets flagged through `err_overflow`.

## Test plan
- Reset, then bytes A1, B2, C3, D4 on consecutive cycles -> one-cycle `input_buffer_loaded`, `data_out == 32'hA1B2C3D4`, `ready_to_receive` low until `data_routed`.
- After a load, hold `data_routed` low for 10 cycles with strobes on 3 of them -> `data_out` unchanged, three `err_overflow` pulses. Then pulse `data_routed` and send 11, 22, 33, 44 -> `data_out == 32'h11223344`.
- `IDLE_TIMEOUT=4`; send 2 bytes, idle 4 cycles -> `err_timeout` pulse, `cnt` back to 0. Then send 4 new bytes -> packet built from the new bytes only, and the previous `data_out` is untouched until completion.
- Send 3 bytes, then the 4th exactly on the expiry cycle -> byte accepted, no `err_timeout`, packet loads.
- Fourth byte and `data_routed` on the same edge -> `data_routed` ignored, block stays in FULL. A second `data_routed` releases it.
- Assert `reset_n` low asynchronously mid-packet and again in FULL -> all outputs go to reset values immediately, no error pulses, and the next 4 bytes form a clean packet.
